// File: rtl/rr_arb_mux_if.sv
// rtl/rr_arb_mux_if.sv - handshake bundle for the N-channel arbitrating mux
interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 6,
  parameter int SELW  = $clog2(N)
);
  logic                      rr_en;
  logic [N-1:0][WIDTH-1:0]   in_data;
  logic [N-1:0]              in_valid;
  logic [N-1:0]              in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SELW-1:0]           out_sel;
  logic                      out_valid;
  logic                      out_ready;

  // Sources and the downstream consumer drive this side
  modport master (
    output rr_en, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  // The arbitrating mux itself
  modport slave (
    input  rr_en, in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel round-robin/fixed-priority mux with registered output
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_arb_mux_if.slave bus
);
  localparam int SELW = $clog2(N);

  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_sel_q;
  logic             out_valid_q;
  logic [SELW-1:0]  ptr;

  logic [SELW-1:0]  gidx;
  logic             gany;
  logic             can_load;
  logic             xfer;
  logic [SELW-1:0]  ptr_nxt;
  logic [N-1:0]     rdy;

  // The output register may take a new word when empty or being drained this cycle
  assign can_load = !out_valid_q || bus.out_ready;
  assign xfer     = gany && can_load;
  // Pointer wraps at N rather than 2^SELW so non-power-of-two N stays in range
  assign ptr_nxt  = (gidx == SELW'(N - 1)) ? '0 : gidx + 1'b1;

  // Pick the winning channel: circular scan from ptr, or lowest index in fixed mode
  always_comb begin : grant_sel
    int c;
    logic [SELW-1:0] cand;
    gidx = '0;
    gany = 1'b0;
    c    = 0;
    cand = '0;
    if (bus.rr_en) begin
      for (int i = 0; i < N; i++) begin
        c = int'(ptr) + i;
        if (c >= N) c = c - N;
        cand = SELW'(c);
        if (!gany && bus.in_valid[cand]) begin
          gany = 1'b1;
          gidx = cand;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        cand = SELW'(i);
        if (bus.in_valid[cand]) begin
          gany = 1'b1;
          gidx = cand;
        end
      end
    end
  end

  // One-hot ready to the winner only; held low throughout reset
  always_comb begin
    rdy = '0;
    if (rst_n && xfer) rdy[gidx] = 1'b1;
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr         <= '0;
    end else begin
      if (xfer) begin
        out_data_q  <= bus.in_data[gidx];
        out_sel_q   <= gidx;
        out_valid_q <= 1'b1;
        if (bus.rr_en) ptr <= ptr_nxt;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - self-checking bench for rr_arb_mux
module tb_rr_arb_mux;
  localparam int WIDTH = 32;
  localparam int N     = 6;

  typedef struct {
    logic        rr;
    logic [5:0]  vld;
    logic        ordy;
    logic [5:0]  rdy;
    logic        ov;
    logic [2:0]  sel;
    logic [31:0] dat;
    logic [2:0]  ptr;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  vec_t tbl[$];

  rr_arb_mux_if #(.WIDTH(WIDTH), .N(N)) bus ();

  rr_arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rr, input logic [5:0] vld, input logic ordy,
                     input logic [5:0] rdy, input logic ov, input logic [2:0] sel,
                     input logic [31:0] dat, input logic [2:0] ptr);
    vec_t v;
    v.rr = rr; v.vld = vld; v.ordy = ordy; v.rdy = rdy;
    v.ov = ov; v.sel = sel; v.dat = dat; v.ptr = ptr;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [2:0] sel,
                         input logic [31:0] dat);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".out_sel"},   32'(bus.out_sel),   32'(sel));
    chk({tag, ".out_data"},  bus.out_data,       dat);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // rr, valid, out_ready -> in_ready before edge; out_valid, sel, data, ptr after edge
    // fairness: all valid, sequence 0..5,0,1
    add(1, 6'h3F, 1, 6'h01, 1, 0, 32'h100, 1);
    add(1, 6'h3F, 1, 6'h02, 1, 1, 32'h101, 2);
    add(1, 6'h3F, 1, 6'h04, 1, 2, 32'h102, 3);
    add(1, 6'h3F, 1, 6'h08, 1, 3, 32'h103, 4);
    add(1, 6'h3F, 1, 6'h10, 1, 4, 32'h104, 5);
    add(1, 6'h3F, 1, 6'h20, 1, 5, 32'h105, 0);
    add(1, 6'h3F, 1, 6'h01, 1, 0, 32'h100, 1);
    add(1, 6'h3F, 1, 6'h02, 1, 1, 32'h101, 2);
    // steer to ptr=5 via a grant to 4, then wrap/skip over channels 1 and 3
    add(1, 6'h14, 1, 6'h04, 1, 2, 32'h102, 3);
    add(1, 6'h10, 1, 6'h10, 1, 4, 32'h104, 5);
    add(1, 6'h0A, 1, 6'h02, 1, 1, 32'h101, 2);
    add(1, 6'h0A, 1, 6'h08, 1, 3, 32'h103, 4);
    add(1, 6'h0A, 1, 6'h02, 1, 1, 32'h101, 2);
    // fixed priority: 3 beats 5, ptr untouched
    add(0, 6'h28, 1, 6'h08, 1, 3, 32'h103, 2);
    add(0, 6'h28, 1, 6'h08, 1, 3, 32'h103, 2);
    // set ptr=4, hold it through fixed mode, then round-robin picks 5 first
    add(1, 6'h08, 1, 6'h08, 1, 3, 32'h103, 4);
    add(0, 6'h28, 1, 6'h08, 1, 3, 32'h103, 4);
    add(1, 6'h28, 1, 6'h20, 1, 5, 32'h105, 0);
    // idle drain: valid drops, data/sel hold
    add(1, 6'h00, 1, 6'h00, 0, 5, 32'h105, 0);
    add(1, 6'h00, 1, 6'h00, 0, 5, 32'h105, 0);

    rst_n         = 1'b0;
    bus.rr_en     = 1'b1;
    bus.in_valid  = 6'h3F;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) bus.in_data[i] = 32'h100 + 32'(i);
    #2;
    chk_out("reset", 1'b0, 3'd0, 32'h0);
    chk("reset.ptr",      32'(dut.ptr),      32'h0);
    chk("reset.in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      bus.rr_en     = tbl[i].rr;
      bus.in_valid  = tbl[i].vld;
      bus.out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d.in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
      tick();
      chk_out($sformatf("v%0d", i), tbl[i].ov, tbl[i].sel, tbl[i].dat);
      chk($sformatf("v%0d.ptr", i), 32'(dut.ptr), 32'(tbl[i].ptr));
    end

    // Backpressure: 0xDEAD from channel 2 held for 3 stalled cycles
    bus.rr_en      = 1'b1;
    bus.in_data[2] = 32'hDEAD;
    bus.in_valid   = 6'h04;
    bus.out_ready  = 1'b1;
    tick();
    chk_out("bp.load", 1'b1, 3'd2, 32'hDEAD);
    chk("bp.ptr", 32'(dut.ptr), 32'h3);
    bus.in_valid  = 6'h01;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp.stall%0d.in_ready", k), 32'(bus.in_ready), 32'h0);
      tick();
      chk_out($sformatf("bp.stall%0d", k), 1'b1, 3'd2, 32'hDEAD);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release.in_ready", 32'(bus.in_ready), 32'h01);
    tick();
    chk_out("bp.reload", 1'b1, 3'd0, 32'h100);
    bus.in_valid = 6'h00;
    tick();
    chk("bp.drain.out_valid", 32'(bus.out_valid), 32'h0);

    // Idle drain: one word from channel 1, visible for exactly one cycle
    bus.in_data[1] = 32'h111;
    bus.in_valid   = 6'h02;
    tick();
    chk_out("idle.load", 1'b1, 3'd1, 32'h111);
    bus.in_valid = 6'h00;
    tick();
    chk_out("idle.drop", 1'b0, 3'd1, 32'h111);
    tick();
    chk_out("idle.stay", 1'b0, 3'd1, 32'h111);

    // Reset mid-stream while holding 0xA5
    bus.in_data[0] = 32'hA5;
    bus.in_valid   = 6'h01;
    bus.out_ready  = 1'b0;
    tick();
    chk_out("rst.hold", 1'b1, 3'd0, 32'hA5);
    bus.in_data[0] = 32'h100;
    bus.in_valid   = 6'h3F;
    bus.out_ready  = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst.async", 1'b0, 3'd0, 32'h0);
    chk("rst.async.ptr",      32'(dut.ptr),      32'h0);
    chk("rst.async.in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("rst.held.out_valid", 32'(bus.out_valid), 32'h0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst.release.in_ready", 32'(bus.in_ready), 32'h01);
    tick();
    chk_out("rst.first", 1'b1, 3'd0, 32'h100);
    chk("rst.first.ptr", 32'(dut.ptr), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-channel arbitrating multiplexer with a registered output stage. It generalises the combinational select-mux used across the OTTER datapath: instead of an external select, it picks among N valid/ready source channels, either round-robin or fixed-priority. It presents the winner's data with its channel index on a single valid/ready output port. Intended for shared-resource front ends, such as the memory-port and writeback-source merge points in the pipelined OTTER.

## Interface
- WIDTH, default 32: data width per channel.
- N, default 6: channel count; legal range 2..16.
- SELW, default $clog2(N): width of the channel-index output; derived, never overridden.

- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- rr_en  in  1  arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- in_data  in  N×WIDTH (packed [N-1:0][WIDTH-1:0])  per-channel data.
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; at most one bit set per cycle.
- out_data  out  WIDTH  registered data of the accepted channel.
- out_sel  out  SELW  registered index of the accepted channel.
- out_valid  out  1  output register holds an unconsumed word.
- out_ready  in  1  downstream consumer accepts the word this cycle.

## Operation
- State consists of:
  - an output register (out_data, out_sel, out_valid);
  - a priority pointer ptr (SELW bits, range 0..N-1).
- Output register can load (`can_load`) when `!out_valid || out_ready`.
- Grant is combinational and one-hot, or zero when no in_valid is set.
  - Round-robin: grant the first set in_valid scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Fixed: grant the lowest set in_valid index. ptr is ignored and not updated.
- in_ready = grant & {N{can_load}}. A transfer on channel g occurs when in_valid[g] && in_ready[g].
- On transfer:
  - out_data <= in_data[g];
  - out_sel <= g;
  - out_valid <= 1.
  - If rr_en, ptr <= (g == N-1) ? 0 : g+1. Wrap is at N, not 2^SELW.
- If out_ready && out_valid and there is no transfer: out_valid <= 0. out_data and out_sel hold their last values.
- If out_valid && !out_ready: out_data, out_sel and out_valid hold, and all in_ready are 0.
- Simultaneous consume and transfer in the same cycle: the register reloads with the new word and out_valid stays 1. This gives full throughput.
- rr_en change: takes effect in the same cycle's grant. ptr retains its value across fixed-mode periods.
- Protocol obligations:
  - Sources must not drop in_valid or change in_data while waiting.
  - in_ready may depend combinationally on in_valid; no input valid may depend on in_ready.

## Timing
- Reset (RST_N low, asynchronous, any time):
  - out_valid = 0, out_data = 0, out_sel = 0, ptr = 0.
  - in_ready = 0 while RST_N is low.
  - Any transfer in flight is discarded.
- First edge after release: normal arbitration; channel 0 has highest round-robin priority.
- Latency: input transfer at edge k, so out_valid/out_data visible after edge k, consumable at edge k+1.
- Throughput: one word per cycle when out_ready is held high.
- No combinational path from in_data to out_data.
- Combinational path exists from out_ready and in_valid to in_ready.
- Fairness: in round-robin with all N channels continuously valid and out_ready = 1, each channel is granted exactly once per N consecutive transfers.

## Test plan
- Reset mid-stream: out_valid = 1 holding 0xA5, assert RST_N = 0 between edges -> out_valid, out_data and out_sel go to 0 immediately, without waiting for an edge; after release, channel 0 wins first.
- Round-robin fairness: N = 6, rr_en = 1, all in_valid = 1, in_data[i] = 0x100+i, out_ready = 1 -> out_sel sequence 0,1,2,3,4,5,0,1 on consecutive cycles, out_data 0x100..0x105 then 0x100, 0x101.
- Pointer wrap and skip: rr_en = 1, ptr = 5 after a grant to 4, only channels 1 and 3 valid -> grant 1, then 3, then 1; ptr values 2, 4, 2.
- Backpressure: out_ready = 0 for 3 cycles after a load of 0xDEAD from channel 2 -> out_data = 0xDEAD, out_sel = 2 held, all in_ready = 0; out_ready = 1 -> next word loads in the same cycle and out_valid stays 1.
- Fixed priority and mode switch: rr_en = 0, channels 3 and 5 valid -> 3 granted repeatedly while valid and ptr unchanged. Switch rr_en = 1 with ptr = 4 -> 5 is granted first.
- Idle drain: single transfer on channel 1, then no in_valid, out_ready = 1 -> out_valid high for exactly one cycle, then 0, with out_data holding the channel-1 value.
